mem_port_arbiter: RTL

- Shares one single-port, variable-latency unified memory between the IF-stage instruction fetch and the MEM-stage data access of the 5-stage pipeline.
- Sequences memory transactions with a req/ack handshake.
- Returns fetched or loaded data to each requester and drives one global pipeline stall until every active request in the current pipeline step has been served.

---
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, variable-latency unified memory between
// the IF-stage instruction fetch and the MEM-stage data access. Data accesses win
// over fetches, and one global stall holds the pipeline until every active request
// of the current step is served.
// Optional build macro MEM_PORT_ARBITER_WBUF_EN adds a one-entry posted write buffer.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ready_o,
    input  logic              dm_read_i,
    input  logic              dm_write_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ready_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {StIdle, StDmAcc, StIfAcc, StWbDrain} state_e;

    state_e state_q;
    logic   if_done_q;
    logic   dm_done_q;
    logic   dm_req;
    logic   dm_pend;
    logic   if_pend;

`ifdef MEM_PORT_ARBITER_WBUF_EN
    logic              wb_valid_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              wb_hit;

    // Word match only; byte offset bits are ignored by the memory anyway.
    assign wb_hit = wb_valid_q & (dm_addr_i[ADDR_W-1:2] == wb_addr_q[ADDR_W-1:2]);
`endif

    // Pending = requested in this step and not yet served.
    assign dm_req     = dm_read_i | dm_write_i;
    assign dm_pend    = dm_req & ~dm_done_q;
    assign if_pend    = if_req_i & ~if_done_q;
    // Gated by reset so the pipeline sees no stall while the arbiter is held.
    assign stall_o    = ~rst_i & (if_pend | dm_pend);
    assign if_ready_o = if_done_q;
    assign dm_ready_o = dm_done_q;

    // Arbitration FSM with registered memory-side and requester-side outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            if_data_o   <= '0;
            dm_rdata_o  <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
`ifdef MEM_PORT_ARBITER_WBUF_EN
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
`endif
        end else begin
            // Pipeline advances on this edge: the next step starts with nothing done.
            if (!stall_o) begin
                if_done_q <= 1'b0;
                dm_done_q <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (dm_pend) begin
`ifdef MEM_PORT_ARBITER_WBUF_EN
                        if (dm_write_i && !wb_valid_q) begin
                            wb_valid_q <= 1'b1;
                            wb_addr_q  <= dm_addr_i;
                            wb_data_q  <= dm_wdata_i;
                            dm_done_q  <= 1'b1;
                        end else if (dm_read_i && wb_hit) begin
                            dm_rdata_o <= wb_data_q;
                            dm_done_q  <= 1'b1;
                        end else if (wb_valid_q) begin
                            // Older posted store must reach memory before this access.
                            state_q     <= StWbDrain;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= 1'b1;
                            mem_addr_o  <= wb_addr_q;
                            mem_wdata_o <= wb_data_q;
                        end else
`endif
                        begin
                            state_q     <= StDmAcc;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= dm_write_i;
                            mem_addr_o  <= dm_addr_i;
                            mem_wdata_o <= dm_wdata_i;
                        end
                    end else if (if_pend) begin
                        state_q    <= StIfAcc;
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= if_addr_i;
                    end
`ifdef MEM_PORT_ARBITER_WBUF_EN
                    // Drain only in a step with no traffic so a following load can
                    // still hit the buffer.
                    else if (wb_valid_q && !if_req_i && !dm_req) begin
                        state_q     <= StWbDrain;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= wb_addr_q;
                        mem_wdata_o <= wb_data_q;
                    end
`endif
                end
                StDmAcc: begin
                    if (mem_ack_i) begin
                        if (!mem_we_o) begin
                            dm_rdata_o <= mem_rdata_i;
                        end
                        dm_done_q <= 1'b1;
                        mem_req_o <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                StIfAcc: begin
                    if (mem_ack_i) begin
                        if_data_o <= mem_rdata_i;
                        if_done_q <= 1'b1;
                        mem_req_o <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
`ifdef MEM_PORT_ARBITER_WBUF_EN
                StWbDrain: begin
                    if (mem_ack_i) begin
                        wb_valid_q <= 1'b0;
                        mem_req_o  <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
`endif
                default: begin
                    mem_req_o <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule
